// File: rtl/bench_sweep_sequencer_pkg.sv
// Shared types for the benchmark sweep sequencer: FSM state encodings,
// winner codes and the registered engine result vector.
package bench_sweep_sequencer_pkg;

   typedef enum logic [2:0] {
      SWP_IDLE   = 3'd0,
      SWP_LAUNCH = 3'd1,
      SWP_WAIT   = 3'd2,
      SWP_ACCUM  = 3'd3,
      SWP_GAP    = 3'd4,
      SWP_DRAIN  = 3'd5
   } swp_state_e;

   localparam logic [1:0] WIN_B2  = 2'd0;
   localparam logic [1:0] WIN_B10 = 2'd1;
   localparam logic [1:0] WIN_B12 = 2'd2;
   localparam logic [1:0] WIN_RTR = 2'd3;

   typedef struct packed {
      logic [1:0]       winner;
      logic [31:0]      runtime;
      logic [3:0][31:0] t_cond;
   } eng_result_t;

endpackage

// File: rtl/bench_sweep_sequencer_if.sv
// Link between the sweep sequencer (master) and bench_engine (slave):
// launch pulse out, done pulse and result vector back.
interface bench_sweep_sequencer_if;
   logic        eng_start;
   logic        eng_done;
   logic [1:0]  eng_winner_code;
   logic [31:0] eng_t_cond0;
   logic [31:0] eng_t_cond1;
   logic [31:0] eng_t_cond2;
   logic [31:0] eng_t_cond3;
   logic [31:0] eng_t_runtime;

   modport master (
      output eng_start,
      input  eng_done, eng_winner_code, eng_t_cond0, eng_t_cond1,
             eng_t_cond2, eng_t_cond3, eng_t_runtime
   );

   modport slave (
      input  eng_start,
      output eng_done, eng_winner_code, eng_t_cond0, eng_t_cond1,
             eng_t_cond2, eng_t_cond3, eng_t_runtime
   );
endinterface

// File: rtl/bench_sweep_sequencer_stats_accum.sv
// Sweep statistics: per-condition cycle sums, winner tallies and min/max
// runtime. Cleared on sweep start, updated once per accepted run.
module sweep_stats_accum
   import bench_sweep_sequencer_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int SUM_W = 48
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clear,
   input  logic                        accum_en,
   input  eng_result_t                 res,
   output logic [3:0][CNT_W-1:0]       win_cnt,
   output logic [3:0][SUM_W-1:0]       sum_cond,
   output logic [31:0]                 rt_min,
   output logic [31:0]                 rt_max
);

   logic [3:0][CNT_W-1:0] win_q, win_d;
   logic [3:0][SUM_W-1:0] sum_q, sum_d;
   logic [31:0]           rt_min_q, rt_min_d;
   logic [31:0]           rt_max_q, rt_max_d;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the branches below can leave it unassigned (no latch).
      win_d    = win_q;
      sum_d    = sum_q;
      rt_min_d = rt_min_q;
      rt_max_d = rt_max_q;
      if (clear) begin
         win_d    = '0;
         sum_d    = '0;
         rt_min_d = '1;
         rt_max_d = '0;
      end else if (accum_en) begin
         for (int k = 0; k < 4; k++) begin
            sum_d[k] = sum_q[k] + SUM_W'(res.t_cond[k]);
         end
         win_d[res.winner] = win_q[res.winner] + CNT_W'(1);
         if (res.runtime < rt_min_q) rt_min_d = res.runtime;
         if (res.runtime > rt_max_q) rt_max_d = res.runtime;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         win_q    <= '0;
         sum_q    <= '0;
         rt_min_q <= '1;
         rt_max_q <= '0;
      end else begin
         win_q    <= win_d;
         sum_q    <= sum_d;
         rt_min_q <= rt_min_d;
         rt_max_q <= rt_max_d;
      end
   end

   assign win_cnt  = win_q;
   assign sum_cond = sum_q;
   assign rt_min   = rt_min_q;
   assign rt_max   = rt_max_q;

endmodule

// File: rtl/bench_sweep_sequencer.sv
// Runs bench_engine N times back-to-back and accumulates sweep statistics.
// Optional per-run watchdog and timeout output: define SWEEP_TIMEOUT_EN.
module bench_sweep_sequencer
   import bench_sweep_sequencer_pkg::*;
#(
   parameter int CNT_W          = 16,
   parameter int SUM_W          = 48,
   parameter int GAP_CYCLES     = 16,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_start,
   input  logic                     cmd_abort,
   input  logic [CNT_W-1:0]         cfg_runs,
   bench_sweep_sequencer_if.master  eng,
   output logic                     busy,
   output logic                     done,
   output logic                     aborted,
   output logic [CNT_W-1:0]         runs_done,
   output logic [CNT_W-1:0]         win_cnt0,
   output logic [CNT_W-1:0]         win_cnt1,
   output logic [CNT_W-1:0]         win_cnt2,
   output logic [CNT_W-1:0]         win_cnt3,
   output logic [SUM_W-1:0]         sum_cond0,
   output logic [SUM_W-1:0]         sum_cond1,
   output logic [SUM_W-1:0]         sum_cond2,
   output logic [SUM_W-1:0]         sum_cond3,
   output logic [31:0]              rt_min,
   output logic [31:0]              rt_max
`ifdef SWEEP_TIMEOUT_EN
   ,
   output logic                     timeout
`endif
);

   localparam logic [31:0] GAP_LAST = (GAP_CYCLES > 0) ? 32'(GAP_CYCLES - 1) : 32'd0;

   swp_state_e           state_q, state_d;
   logic [CNT_W-1:0]     runs_q, runs_d;
   logic [CNT_W-1:0]     runs_done_q, runs_done_d, runs_done_inc;
   logic                 done_q, done_d;
   logic                 aborted_q, aborted_d;
   logic [31:0]          gap_q, gap_d;
   eng_result_t          res_q, res_d;
   logic                 stats_clear, accum_en;
   logic [3:0][CNT_W-1:0] win_cnt;
   logic [3:0][SUM_W-1:0] sum_cond;
`ifdef SWEEP_TIMEOUT_EN
   localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
   logic [31:0]          wdog_q, wdog_d;
   logic                 timeout_q, timeout_d;
`endif

   assign runs_done_inc = runs_done_q + CNT_W'(1);

   always_comb begin
      state_d     = state_q;
      runs_d      = runs_q;
      runs_done_d = runs_done_q;
      done_d      = done_q;
      aborted_d   = aborted_q;
      gap_d       = gap_q;
      res_d       = res_q;
      stats_clear = 1'b0;
      accum_en    = 1'b0;
`ifdef SWEEP_TIMEOUT_EN
      timeout_d   = timeout_q;
      wdog_d      = wdog_q;
      if (state_q == SWP_WAIT || state_q == SWP_DRAIN) wdog_d = wdog_q + 32'd1;
`endif
      case (state_q)
         SWP_IDLE: begin
            // Start outranks a coincident abort; abort alone is a no-op here.
            if (cmd_start) begin
               runs_d      = cfg_runs;
               runs_done_d = '0;
               done_d      = 1'b0;
               aborted_d   = 1'b0;
               stats_clear = 1'b1;
`ifdef SWEEP_TIMEOUT_EN
               timeout_d   = 1'b0;
`endif
               if (cfg_runs == '0) done_d  = 1'b1;
               else                state_d = SWP_LAUNCH;
            end
         end
         SWP_LAUNCH: begin
`ifdef SWEEP_TIMEOUT_EN
            wdog_d = '0;
`endif
            state_d = cmd_abort ? SWP_DRAIN : SWP_WAIT;
         end
         SWP_WAIT: begin
            if (eng.eng_done) begin
               if (cmd_abort) begin
                  aborted_d = 1'b1;
                  state_d   = SWP_IDLE;
               end else begin
                  res_d.winner    = eng.eng_winner_code;
                  res_d.runtime   = eng.eng_t_runtime;
                  res_d.t_cond[0] = eng.eng_t_cond0;
                  res_d.t_cond[1] = eng.eng_t_cond1;
                  res_d.t_cond[2] = eng.eng_t_cond2;
                  res_d.t_cond[3] = eng.eng_t_cond3;
                  state_d         = SWP_ACCUM;
               end
            end else if (cmd_abort) begin
               state_d = SWP_DRAIN;
`ifdef SWEEP_TIMEOUT_EN
            end else if (wdog_q == TO_LAST) begin
               aborted_d = 1'b1;
               timeout_d = 1'b1;
               state_d   = SWP_IDLE;
`endif
            end
         end
         SWP_ACCUM: begin
            accum_en    = 1'b1;
            runs_done_d = runs_done_inc;
            if (runs_done_inc == runs_q) begin
               done_d  = 1'b1;
               state_d = SWP_IDLE;
            end else if (cmd_abort) begin
               aborted_d = 1'b1;
               state_d   = SWP_IDLE;
            end else if (GAP_CYCLES == 0) begin
               state_d = SWP_LAUNCH;
            end else begin
               gap_d   = '0;
               state_d = SWP_GAP;
            end
         end
         SWP_GAP: begin
            if (cmd_abort) begin
               aborted_d = 1'b1;
               state_d   = SWP_IDLE;
            end else if (gap_q == GAP_LAST) begin
               state_d = SWP_LAUNCH;
            end else begin
               gap_d = gap_q + 32'd1;
            end
         end
         SWP_DRAIN: begin
            // The engine cannot be stopped; its result is discarded.
            if (eng.eng_done) begin
               aborted_d = 1'b1;
               state_d   = SWP_IDLE;
`ifdef SWEEP_TIMEOUT_EN
            end else if (wdog_q == TO_LAST) begin
               aborted_d = 1'b1;
               timeout_d = 1'b1;
               state_d   = SWP_IDLE;
`endif
            end
         end
         default: state_d = SWP_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= SWP_IDLE;
         runs_q      <= '0;
         runs_done_q <= '0;
         done_q      <= 1'b0;
         aborted_q   <= 1'b0;
         gap_q       <= '0;
         res_q       <= '0;
`ifdef SWEEP_TIMEOUT_EN
         wdog_q      <= '0;
         timeout_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         runs_q      <= runs_d;
         runs_done_q <= runs_done_d;
         done_q      <= done_d;
         aborted_q   <= aborted_d;
         gap_q       <= gap_d;
         res_q       <= res_d;
`ifdef SWEEP_TIMEOUT_EN
         wdog_q      <= wdog_d;
         timeout_q   <= timeout_d;
`endif
      end
   end

   sweep_stats_accum #(
      .CNT_W (CNT_W),
      .SUM_W (SUM_W)
   ) u_stats (
      .clk      (clk),
      .rst      (rst),
      .clear    (stats_clear),
      .accum_en (accum_en),
      .res      (res_q),
      .win_cnt  (win_cnt),
      .sum_cond (sum_cond),
      .rt_min   (rt_min),
      .rt_max   (rt_max)
   );

   assign eng.eng_start = (state_q == SWP_LAUNCH);
   assign busy          = (state_q != SWP_IDLE);
   assign done          = done_q;
   assign aborted       = aborted_q;
   assign runs_done     = runs_done_q;
   assign win_cnt0      = win_cnt[0];
   assign win_cnt1      = win_cnt[1];
   assign win_cnt2      = win_cnt[2];
   assign win_cnt3      = win_cnt[3];
   assign sum_cond0     = sum_cond[0];
   assign sum_cond1     = sum_cond[1];
   assign sum_cond2     = sum_cond[2];
   assign sum_cond3     = sum_cond[3];
`ifdef SWEEP_TIMEOUT_EN
   assign timeout       = timeout_q;
`endif

endmodule

// File: tb/tb_bench_sweep_sequencer.sv
// Directed bench for bench_sweep_sequencer with a behavioural engine model
// and a scoreboard of expected end-of-sweep statistics.
module tb_bench_sweep_sequencer;
   import bench_sweep_sequencer_pkg::*;

   localparam int CNT_W = 16;
   localparam int SUM_W = 48;

   logic             clk = 1'b0;
   logic             rst;
   logic             cmd_start;
   logic             cmd_abort;
   logic [CNT_W-1:0] cfg_runs;
   logic             busy, done, aborted;
   logic [CNT_W-1:0] runs_done, win_cnt0, win_cnt1, win_cnt2, win_cnt3;
   logic [SUM_W-1:0] sum_cond0, sum_cond1, sum_cond2, sum_cond3;
   logic [31:0]      rt_min, rt_max;
`ifdef SWEEP_TIMEOUT_EN
   logic             timeout;
`endif

   bench_sweep_sequencer_if eng ();

   always #5 clk = ~clk;

   bench_sweep_sequencer #(
      .CNT_W          (CNT_W),
      .SUM_W          (SUM_W),
      .GAP_CYCLES     (2),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_start (cmd_start),
      .cmd_abort (cmd_abort),
      .cfg_runs  (cfg_runs),
      .eng       (eng),
      .busy      (busy),
      .done      (done),
      .aborted   (aborted),
      .runs_done (runs_done),
      .win_cnt0  (win_cnt0),
      .win_cnt1  (win_cnt1),
      .win_cnt2  (win_cnt2),
      .win_cnt3  (win_cnt3),
      .sum_cond0 (sum_cond0),
      .sum_cond1 (sum_cond1),
      .sum_cond2 (sum_cond2),
      .sum_cond3 (sum_cond3),
      .rt_min    (rt_min),
      .rt_max    (rt_max)
`ifdef SWEEP_TIMEOUT_EN
      ,
      .timeout   (timeout)
`endif
   );

   // Per-run engine results, indexed by launch number within the sweep.
   logic [31:0] tab_rt [8];
   logic [1:0]  tab_win[8];
   logic [31:0] tab_c  [8][4];

   int  starts     = 0;
   int  sweep_base = 0;
   bit  model_en   = 1'b1;
   bit  stray_en   = 1'b0;
   int  checks     = 0;
   int  errors     = 0;

   typedef struct {
      logic [SUM_W-1:0] sum[4];
      logic [CNT_W-1:0] win[4];
      logic [31:0]      mn;
      logic [31:0]      mx;
      logic [CNT_W-1:0] rd;
      logic             dn;
      logic             ab;
      int               st;
   } exp_t;

   exp_t sb[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input int n_acc, input int n_st, input logic dn, input logic ab);
      exp_t e;
      for (int k = 0; k < 4; k++) begin
         e.sum[k] = '0;
         e.win[k] = '0;
      end
      e.mn = '1;
      e.mx = '0;
      for (int i = 0; i < n_acc; i++) begin
         for (int k = 0; k < 4; k++) e.sum[k] += SUM_W'(tab_c[i][k]);
         e.win[tab_win[i]] += 1;
         if (tab_rt[i] < e.mn) e.mn = tab_rt[i];
         if (tab_rt[i] > e.mx) e.mx = tab_rt[i];
      end
      e.rd = CNT_W'(n_acc);
      e.dn = dn;
      e.ab = ab;
      e.st = n_st;
      return e;
   endfunction

   // Engine model: done 10 cycles after each launch; optional stray done
   // two cycles after the first run's done (lands in GAP).
   initial begin
      int pend = 0;
      int pidx = 0;
      int stray_cnt = 0;
      eng.eng_done        = 1'b0;
      eng.eng_winner_code = WIN_B2;
      eng.eng_t_cond0     = '0;
      eng.eng_t_cond1     = '0;
      eng.eng_t_cond2     = '0;
      eng.eng_t_cond3     = '0;
      eng.eng_t_runtime   = '0;
      forever begin
         @(negedge clk);
         eng.eng_done = 1'b0;
         if (stray_cnt > 0) begin
            stray_cnt--;
            if (stray_cnt == 0) begin
               eng.eng_done        = 1'b1;
               eng.eng_winner_code = WIN_B2;
               eng.eng_t_cond0     = 32'hdead_beef;
               eng.eng_t_cond1     = 32'hdead_beef;
               eng.eng_t_cond2     = 32'hdead_beef;
               eng.eng_t_cond3     = 32'hdead_beef;
               eng.eng_t_runtime   = 32'd1;
            end
         end
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               eng.eng_done        = 1'b1;
               eng.eng_winner_code = tab_win[pidx];
               eng.eng_t_cond0     = tab_c[pidx][0];
               eng.eng_t_cond1     = tab_c[pidx][1];
               eng.eng_t_cond2     = tab_c[pidx][2];
               eng.eng_t_cond3     = tab_c[pidx][3];
               eng.eng_t_runtime   = tab_rt[pidx];
               if (stray_en && pidx == 0) stray_cnt = 2;
            end
         end
         if (eng.eng_start) begin
            pidx = (starts - sweep_base) & 7;
            starts++;
            if (model_en) pend = 10;
         end
      end
   end

   task automatic pulse_start(input logic [CNT_W-1:0] n);
      cfg_runs   = n;
      sweep_base = starts;
      cmd_start  = 1'b1;
      @(negedge clk);
      cmd_start  = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("idle_reached", busy, 1'b0);
   endtask

   task automatic wait_starts(input int target, input int budget);
      int n = 0;
      while ((starts - sweep_base) < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("launch_seen", 64'(starts - sweep_base), 64'(target));
   endtask

   task automatic compare_sweep(input string tag);
      exp_t e;
      check({tag, "_sb_nonempty"}, sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check({tag, "_sum0"}, sum_cond0, e.sum[0]);
         check({tag, "_sum1"}, sum_cond1, e.sum[1]);
         check({tag, "_sum2"}, sum_cond2, e.sum[2]);
         check({tag, "_sum3"}, sum_cond3, e.sum[3]);
         check({tag, "_win0"}, win_cnt0, e.win[0]);
         check({tag, "_win1"}, win_cnt1, e.win[1]);
         check({tag, "_win2"}, win_cnt2, e.win[2]);
         check({tag, "_win3"}, win_cnt3, e.win[3]);
         check({tag, "_rt_min"}, rt_min, e.mn);
         check({tag, "_rt_max"}, rt_max, e.mx);
         check({tag, "_runs_done"}, runs_done, e.rd);
         check({tag, "_done"}, done, e.dn);
         check({tag, "_aborted"}, aborted, e.ab);
         check({tag, "_starts"}, 64'(starts - sweep_base), 64'(e.st));
      end
   endtask

   initial begin
      rst       = 1'b1;
      cmd_start = 1'b0;
      cmd_abort = 1'b0;
      cfg_runs  = '0;
      for (int i = 0; i < 8; i++) begin
         tab_rt[i]  = '0;
         tab_win[i] = '0;
         for (int k = 0; k < 4; k++) tab_c[i][k] = '0;
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_aborted", aborted, 1'b0);
      check("rst_runs_done", runs_done, '0);
      check("rst_rt_min", rt_min, 32'hFFFF_FFFF);
      check("rst_rt_max", rt_max, '0);
      check("rst_sum0", sum_cond0, '0);
      check("rst_win1", win_cnt1, '0);
      check("rst_eng_start", eng.eng_start, 1'b0);

      // Three runs, fixed conditions, winner 1.
      for (int i = 0; i < 3; i++) begin
         tab_c[i][0] = 32'd100; tab_c[i][1] = 32'd200;
         tab_c[i][2] = 32'd300; tab_c[i][3] = 32'd400;
         tab_win[i]  = WIN_B10;
      end
      tab_rt[0] = 32'd50; tab_rt[1] = 32'd40; tab_rt[2] = 32'd60;
      sb.push_back(model(3, 3, 1'b1, 1'b0));
      pulse_start(16'd3);
      check("t1_launch_pulse", eng.eng_start, 1'b1);
      check("t1_busy", busy, 1'b1);
      wait_idle(500);
      compare_sweep("t1");
      check("t1_sum0_abs", sum_cond0, 48'd300);
      check("t1_sum3_abs", sum_cond3, 48'd1200);

      // Zero runs: done next cycle, no launch, stats cleared.
      sb.push_back(model(0, 0, 1'b1, 1'b0));
      pulse_start(16'd0);
      check("t2_done", done, 1'b1);
      check("t2_busy", busy, 1'b0);
      check("t2_eng_start", eng.eng_start, 1'b0);
      repeat (20) @(negedge clk);
      compare_sweep("t2");

      // Five runs, abort during the second run's WAIT.
      for (int i = 0; i < 5; i++) begin
         for (int k = 0; k < 4; k++) tab_c[i][k] = 32'(i * 7 + k * 1000 + 3);
         tab_rt[i]  = 32'(30 - i);
         tab_win[i] = WIN_B12;
      end
      sb.push_back(model(1, 2, 1'b0, 1'b1));
      pulse_start(16'd5);
      wait_starts(2, 200);
      repeat (3) @(negedge clk);
      cmd_abort = 1'b1;
      @(negedge clk);
      cmd_abort = 1'b0;
      check("t3_busy_drain", busy, 1'b1);
      wait_idle(200);
      compare_sweep("t3");
      repeat (40) @(negedge clk);
      check("t3_no_more_launch", 64'(starts - sweep_base), 64'd2);

      // Four runs, winners 0,2,3,3; mid-sweep restart and stray done ignored.
      tab_win[0] = WIN_B2;  tab_win[1] = WIN_B12;
      tab_win[2] = WIN_RTR; tab_win[3] = WIN_RTR;
      tab_rt[0] = 32'd500; tab_rt[1] = 32'd7; tab_rt[2] = 32'hFFFF_FFF0; tab_rt[3] = 32'd90;
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 4; k++) tab_c[i][k] = 32'hF000_0000 + 32'(i * 16 + k);
      stray_en = 1'b1;
      sb.push_back(model(4, 4, 1'b1, 1'b0));
      pulse_start(16'd4);
      wait_starts(2, 200);
      cfg_runs  = 16'd9;
      cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      wait_idle(1000);
      compare_sweep("t4");
      check("t4_win3_abs", win_cnt3, 16'd2);
      check("t4_tally_total", 64'(win_cnt0) + 64'(win_cnt1) + 64'(win_cnt2) + 64'(win_cnt3),
            64'(runs_done));
      stray_en = 1'b0;

`ifdef SWEEP_TIMEOUT_EN
      // Engine never answers: watchdog ends the sweep after 100 WAIT cycles.
      begin
         int n;
         model_en = 1'b0;
         pulse_start(16'd2);
         n = 1;
         while (busy && n < 400) begin
            @(negedge clk);
            n++;
         end
         check("t5_timeout_latency", 64'(n), 64'd102);
         check("t5_timeout", timeout, 1'b1);
         check("t5_aborted", aborted, 1'b1);
         check("t5_done", done, 1'b0);
         check("t5_runs_done", runs_done, '0);
         model_en = 1'b1;
      end
`endif

      // Reset in the middle of a sweep returns everything to reset values.
      pulse_start(16'd3);
      begin
         int n = 0;
         while (runs_done == '0 && n < 200) begin
            @(negedge clk);
            n++;
         end
      end
      check("t6_mid_sweep", runs_done, 16'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t6_busy", busy, 1'b0);
      check("t6_runs_done", runs_done, '0);
      check("t6_rt_min", rt_min, 32'hFFFF_FFFF);
      check("t6_sum0", sum_cond0, '0);
      repeat (30) @(negedge clk);
      check("t6_still_idle", busy, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
